// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcodes, FSM states and access-size helpers shared by the memory-access stage.
package mem_access_unit_pkg;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_FIN} state_e;
    typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD, ACC_NONE} acc_size_e;
    function automatic acc_size_e acc_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return ACC_BYTE;
            OP_LH, OP_LHU, OP_SH: return ACC_HALF;
            OP_LW, OP_SW:         return ACC_WORD;
            default:              return ACC_NONE;
        endcase
    endfunction
    function automatic logic is_load(input logic [5:0] op);
        return op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU || op == OP_LW;
    endfunction
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a read word and sign/zero-extends it.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [5:0]  op,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        data = op == OP_LB  ? {{24{b[7]}}, b} :
               op == OP_LBU ? {24'b0, b} :
               op == OP_LH  ? {{16{h[15]}}, h} :
               op == OP_LHU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one controller memory strobe into a handshaked word-memory transaction,
// with sub-word stores done as read-modify-write and extended loads returned in mdr.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);
    state_e            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, mdr_q, mdr_d, m_wdata_q, m_wdata_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic              err_q, err_d, busy_q, busy_d, done_q, done_d, m_req_q, m_req_d, m_we_q, m_we_d;
    logic              req_err;
    logic [DATA_W-1:0] ld_data, lane_mask;
    acc_size_e         req_size, cur_size;

    load_extend u_ext (.rdata(m_rdata), .off(off_q), .op(op_q), .data(ld_data));

    always_comb begin
        req_size  = acc_size(op);
        cur_size  = acc_size(op_q);
        req_err   = (mem_read && mem_write) || req_size == ACC_NONE ||
                    (req_size == ACC_HALF && addr[0]) || (req_size == ACC_WORD && addr[1:0] != 2'b00);
        lane_mask = (cur_size == ACC_BYTE ? DATA_W'(32'hFF) : DATA_W'(32'hFFFF)) << {off_q, 3'b000};
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        mdr_d     = mdr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        case (state_q)
            S_IDLE: if (mem_read || mem_write) begin
                op_d     = op;
                off_d    = addr[1:0];
                wdata_d  = wdata;
                m_addr_d = {addr[ADDR_W-1:2], 2'b00};
                err_d    = req_err;
                state_d  = req_err ? S_FIN : op == OP_SW ? S_WR : S_RD;
                m_wdata_d = (!req_err && op == OP_SW) ? wdata : m_wdata_q;
            end
            S_RD: if (m_ack) begin
                // loads finish here; sub-word stores keep the old word as the merge buffer
                mdr_d     = is_load(op_q) ? ld_data : mdr_q;
                m_wdata_d = is_load(op_q) ? m_wdata_q : m_rdata;
                state_d   = is_load(op_q) ? S_FIN : S_MERGE;
            end
            S_MERGE: begin
                m_wdata_d = (m_wdata_q & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
                state_d   = S_WR;
            end
            S_WR:    state_d = m_ack ? S_FIN : S_WR;
            default: state_d = S_IDLE;
        endcase
        m_req_d = state_d == S_RD || state_d == S_WR;
        m_we_d  = state_d == S_WR;
        busy_d  = state_d != S_IDLE;
        done_d  = state_d == S_FIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            mdr_q     <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            off_q     <= off_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            mdr_q     <= mdr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign mdr     = mdr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed transactions against a cycle-schedule model of the memory stage.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 0, rst = 1, mem_read = 0, mem_write = 0, m_ack = 0;
    logic [5:0]  op = '0;
    logic [31:0] addr = '0, wdata = '0, m_rdata = '0;
    logic [31:0] mdr, m_addr, m_wdata;
    logic        busy, done, err, m_req, m_we;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .op(op), .addr(addr),
        .wdata(wdata), .mdr(mdr), .busy(busy), .done(done), .err(err), .m_req(m_req), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    typedef struct packed {
        bit busy, req, we, done, err;
        logic [31:0] addr, wdata, mdr;
    } exp_t;

    exp_t        tab[int];
    logic [31:0] mem[int], mod_mem[int];
    int          waits_q[$];
    int          cyc = 0, n_checks = 0, n_fail = 0, n_rd = 0, n_wr = 0, exp_rd = 0, exp_wr = 0;
    int          n_done = 0, last_done = 0;
    bit          chk_en = 0;
    logic [31:0] idle_mdr = '0;
    logic [5:0]  ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction
    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : init_word(a);
    endfunction
    function automatic logic [31:0] mod_rd(input logic [31:0] a);
        return mod_mem.exists(int'(a)) ? mod_mem[int'(a)] : init_word(a);
    endfunction
    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[int'(a)] = v;
        mod_mem[int'(a)] = v;
    endtask

    function automatic int op_size(input logic [5:0] o);
        case (o)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    // numeric extension: sub-word value minus 2^n when its top bit is set
    function automatic logic [31:0] mod_load(input logic [31:0] w, input logic [1:0] off, input logic [5:0] o);
        int unsigned v;
        int sz;
        sz = op_size(o);
        if (sz == 4) return w;
        v = (w >> (8 * int'(off))) & (sz == 1 ? 32'hFF : 32'hFFFF);
        if (o == OP_LB && v >= 128) v = v - 256;
        if (o == OP_LH && v >= 32768) v = v - 65536;
        return v;
    endfunction

    function automatic logic [31:0] mod_merge(input logic [31:0] w, input logic [1:0] off, input logic [31:0] wd, input int sz);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < sz; i++) r[8 * (int'(off) + i) +: 8] = wd[8 * i +: 8];
        return r;
    endfunction

    // memory responder: per request, waits the queued number of cycles, then acks
    bit r_act = 0;
    int r_w = 0, r_cnt = 0;
    always @(negedge clk) begin
        if (m_req !== 1'b1) begin
            m_ack = 0;
            r_act = 0;
        end else begin
            if (!r_act) begin
                r_act = 1;
                r_cnt = 0;
                if (waits_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req at cycle %0d: got m_req=1, expected none", cyc);
                    r_w = 0;
                end else r_w = waits_q.pop_front();
            end
            if (r_cnt == r_w) begin
                m_ack = 1;
                if (m_we) begin
                    mem[int'(m_addr)] = m_wdata;
                    n_wr++;
                end else begin
                    m_rdata = env_rd(m_addr);
                    n_rd++;
                end
            end else begin
                m_ack = 0;
                m_rdata = $urandom;
                r_cnt++;
            end
        end
    end

    always @(negedge clk) if (done === 1'b1) begin
        n_done++;
        last_done = cyc;
    end

    exp_t cx;
    always @(negedge clk) if (chk_en) begin
        cx = '0;
        cx.mdr = idle_mdr;
        if (tab.exists(cyc)) cx = tab[cyc];
        chk("busy", {31'b0, busy}, {31'b0, cx.busy});
        chk("done", {31'b0, done}, {31'b0, cx.done});
        chk("m_req", {31'b0, m_req}, {31'b0, cx.req});
        if (cx.req) begin
            chk("m_we", {31'b0, m_we}, {31'b0, cx.we});
            chk("m_addr", m_addr, cx.addr);
        end
        if (cx.req && cx.we) chk("m_wdata", m_wdata, cx.wdata);
        if (cx.done) chk("err", {31'b0, err}, {31'b0, cx.err});
        chk("mdr", mdr, cx.mdr);
    end

    task automatic do_txn(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd, input bit dual,
                          input int w1, input int w2, input bit noise, input int abort);
        int c, d, sz;
        bit e, st;
        logic [31:0] wa, old, nw, nm;
        exp_t x;
        c  = cyc;
        sz = op_size(o);
        st = o == OP_SB || o == OP_SH || o == OP_SW;
        e  = dual || sz == 0 || (a % 32'(sz == 0 ? 1 : sz)) != 0;
        wa = {a[31:2], 2'b00};
        old = mod_rd(wa);
        nm = idle_mdr;
        nw = old;
        x = '0;
        x.busy = 1;
        x.addr = wa;
        x.mdr = idle_mdr;
        if (e) d = 1;
        else if (!st) begin
            x.req = 1;
            for (int r = 1; r <= 1 + w1; r++) tab[c + r] = x;
            waits_q.push_back(w1);
            d = 2 + w1;
            nm = mod_load(old, a[1:0], o);
            exp_rd++;
        end else if (sz == 4) begin
            x.req = 1;
            x.we = 1;
            x.wdata = wd;
            for (int r = 1; r <= 1 + w1; r++) tab[c + r] = x;
            waits_q.push_back(w1);
            d = 2 + w1;
            nw = wd;
            if (abort == 0) exp_wr++;
        end else begin
            x.req = 1;
            for (int r = 1; r <= 1 + w1; r++) tab[c + r] = x;
            waits_q.push_back(w1);
            waits_q.push_back(w2);
            exp_rd++;
            x.req = 0;
            tab[c + 2 + w1] = x;
            nw = mod_merge(old, a[1:0], wd, sz);
            x.req = 1;
            x.we = 1;
            x.wdata = nw;
            for (int r = 3 + w1; r <= 3 + w1 + w2; r++) tab[c + r] = x;
            d = 4 + w1 + w2;
            if (abort == 0) exp_wr++;
        end
        x.req = 0;
        x.we = 0;
        x.done = 1;
        x.err = e;
        x.mdr = nm;
        tab[c + d] = x;
        op = o;
        addr = a;
        wdata = wd;
        mem_read = dual || !st;
        mem_write = dual || st;
        for (int i = 1; i <= d; i++) begin
            @(posedge clk);
            #1;
            if (abort == i) begin
                rst = 1;
                mem_read = 0;
                mem_write = 0;
                for (int k = cyc; k < cyc + 64; k++) if (tab.exists(k)) tab.delete(k);
                idle_mdr = '0;
                return;
            end
            mem_read = noise;
            mem_write = noise ? 1'($urandom % 2) : 1'b0;
            op = ops[$urandom % 8];
            addr = $urandom;
            wdata = $urandom;
        end
        @(posedge clk);
        #1;
        mem_read = 0;
        mem_write = 0;
        idle_mdr = nm;
        if (!e && st) mod_mem[int'(wa)] = nw;
    endtask

    initial begin
        int c0, r0, w0, nd, sz;
        logic [5:0]  o;
        logic [31:0] a, low;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_m_we", {31'b0, m_we}, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        rst = 0;
        @(posedge clk);
        #1;
        chk_en = 1;

        set_word(32'h100, 32'hDEADBEEF);
        c0 = cyc;
        do_txn(OP_LW, 32'h100, 32'h0, 0, 2, 0, 0, 0);
        chk("lw_mdr", mdr, 32'hDEADBEEF);
        chk("lw_latency", last_done - c0, 32'd4);
        chk("lw_err", {31'b0, err}, 32'd0);

        set_word(32'h100, 32'h80123456);
        do_txn(OP_LB, 32'h103, 32'h0, 0, 0, 0, 0, 0);
        chk("lb_mdr", mdr, 32'hFFFFFF80);
        do_txn(OP_LBU, 32'h103, 32'h0, 0, 1, 0, 0, 0);
        chk("lbu_mdr", mdr, 32'h00000080);

        set_word(32'h200, 32'h11223344);
        r0 = n_rd;
        w0 = n_wr;
        c0 = cyc;
        do_txn(OP_SB, 32'h201, 32'h000000AB, 0, 0, 0, 0, 0);
        chk("sb_mem", env_rd(32'h200), 32'h1122AB44);
        chk("sb_reads", n_rd - r0, 32'd1);
        chk("sb_writes", n_wr - w0, 32'd1);
        chk("sb_latency", last_done - c0, 32'd4);
        chk("sb_mdr", mdr, 32'h00000080);

        r0 = n_rd;
        c0 = cyc;
        do_txn(OP_LH, 32'h305, 32'h0, 0, 0, 0, 0, 0);
        chk("lh_err", {31'b0, err}, 32'd1);
        chk("lh_latency", last_done - c0, 32'd1);
        chk("lh_noreq", n_rd - r0, 32'd0);

        do_txn(OP_LW, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        chk("dual_err", {31'b0, err}, 32'd1);

        r0 = n_rd;
        do_txn(OP_LW, 32'h104, 32'h0, 0, 3, 0, 1, 0);
        chk("busy_strobe_reads", n_rd - r0, 32'd1);
        chk("busy_strobe_err", {31'b0, err}, 32'd0);

        set_word(32'h400, 32'hCAFEF00D);
        nd = n_done;
        do_txn(OP_SH, 32'h402, 32'h00005555, 0, 0, 5, 0, 4);
        #1;
        chk("abort_m_req", {31'b0, m_req}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        chk("abort_no_done", n_done - nd, 32'd0);
        chk("abort_idle", {31'b0, busy}, 32'd0);
        chk("abort_mem", env_rd(32'h400), 32'hCAFEF00D);
        chk("abort_mdr", mdr, 32'd0);

        for (int i = 0; i < 200; i++) begin
            o = ($urandom % 10 == 0) ? 6'h22 : ops[$urandom % 8];
            sz = op_size(o);
            low = ($urandom % 5 == 0) ? $urandom % 4 : sz == 1 ? $urandom % 4 : sz == 2 ? 2 * ($urandom % 2) : 0;
            a = 32'h800 + ($urandom_range(0, 15) << 2) + low;
            do_txn(o, a, $urandom, $urandom % 20 == 0, $urandom % 4, $urandom % 4, $urandom % 3 == 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        foreach (mod_mem[k]) chk("final_mem", env_rd(32'(k)), mod_mem[k]);
        chk("total_reads", n_rd, exp_rd);
        chk("total_writes", n_wr, exp_wr);
        chk("waits_left", waits_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
